// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch sequencer between PC, instruction memory and decode
module ifetch_unit #(
    parameter int ADDR_W         = 16,
    parameter int INSTR_W        = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_en,
    output logic [1:0]         pc_ctrl,
    output logic [7:0]         offset_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jump_req,
    input  logic [7:0]         jump_target,
    input  logic               halt,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ADV,
        S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mem_req_nxt;
    logic               ir_valid_nxt;
    logic [INSTR_W-1:0] ir_out_nxt;
    logic               pc_en_nxt;
    logic [1:0]         pc_ctrl_nxt;
    logic [7:0]         offset_nxt;
    logic               fetch_err_nxt;

    // PC is held still for the whole request, so the address can come straight from it
    assign mem_addr = pc_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            ir_valid    <= 1'b0;
            ir_out      <= '0;
            pc_en       <= 1'b0;
            pc_ctrl     <= 2'b00;
            offset_addr <= 8'h00;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mem_req     <= mem_req_nxt;
            ir_valid    <= ir_valid_nxt;
            ir_out      <= ir_out_nxt;
            pc_en       <= pc_en_nxt;
            pc_ctrl     <= pc_ctrl_nxt;
            offset_addr <= offset_nxt;
            fetch_err   <= fetch_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mem_req_nxt   = 1'b0;
        ir_valid_nxt  = ir_valid;
        ir_out_nxt    = ir_out;
        pc_en_nxt     = 1'b0;
        pc_ctrl_nxt   = 2'b00;
        offset_nxt    = 8'h00;
        fetch_err_nxt = fetch_err;
        case (state)
            S_IDLE: begin
                if (!halt) begin
                    state_nxt   = S_REQ;
                    mem_req_nxt = 1'b1;
                    cnt_nxt     = '0;
                end
            end
            S_REQ: begin
                // an ack in the final allowed cycle still beats the timeout
                if (mem_ack) begin
                    ir_out_nxt   = mem_rdata;
                    ir_valid_nxt = 1'b1;
                    state_nxt    = S_HOLD;
                end else if (cnt == CNT_LAST) begin
                    fetch_err_nxt = 1'b1;
                    state_nxt     = S_ERR;
                end else begin
                    mem_req_nxt = 1'b1;
                    cnt_nxt     = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (ir_valid && ir_ready) begin
                    ir_valid_nxt = 1'b0;
                    pc_en_nxt    = 1'b1;
                    state_nxt    = S_ADV;
                    if (jump_req) begin
                        pc_ctrl_nxt = 2'b11;
                        offset_nxt  = jump_target;
                    end else begin
                        pc_ctrl_nxt = 2'b01;
                    end
                end
            end
            S_ADV: begin
                if (halt) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt   = S_REQ;
                    mem_req_nxt = 1'b1;
                    cnt_nxt     = '0;
                end
            end
            S_ERR: begin
                fetch_err_nxt = 1'b1;
                ir_valid_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with PC, memory and decode models
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in;
    logic        pc_en;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_req;
    logic [7:0]  jump_target;
    logic        halt;
    logic        fetch_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_pc;

    ifetch_unit #(.ADDR_W(16), .INSTR_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc_ctrl(pc_ctrl),
        .offset_addr(offset_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_out(ir_out), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .jump_req(jump_req), .jump_target(jump_target),
        .halt(halt), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // environment PC register driven by the DUT's control outputs
    always @(posedge clk or negedge rst) begin
        if (!rst) pc_in <= 16'h0000;
        else if (pc_en && pc_ctrl == 2'b01) pc_in <= pc_in + 16'h0001;
        else if (pc_en && pc_ctrl == 2'b11) pc_in <= {8'h00, offset_addr};
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a * 16'h9E37 + 16'h1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ack = 1'b0; ir_ready = 1'b0; jump_req = 1'b0; halt = 1'b0;
        tick();
        rst = 1'b1;
        exp_pc = 16'h0000;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 6) begin
            tick();
            n++;
        end
        check("req_start", {31'd0, mem_req}, 32'd1);
        check("req_addr", {16'd0, mem_addr}, {16'd0, exp_pc});
    endtask

    // one full instruction: request, optional ack delay, decode stall, handshake, PC step
    task automatic fetch_one(input int ack_dly, input int rdy_dly, input bit jmp,
                             input logic [7:0] tgt, input bit noise, input bit halt_adv);
        int          req_cycles;
        logic [15:0] want;
        wait_req();
        want = word_at(exp_pc);
        req_cycles = 1;
        mem_ack = 1'b0;
        check("ir_empty_in_req", {31'd0, ir_valid}, 32'd0);
        for (int i = 0; i < ack_dly; i++) begin
            mem_rdata = 16'($urandom);
            tick();
            if (mem_req) req_cycles++;
            check("addr_stable", {16'd0, mem_addr}, {16'd0, exp_pc});
        end
        check("req_len", req_cycles, ack_dly + 1);
        mem_ack = 1'b1;
        mem_rdata = word_at(mem_addr);
        tick();
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        check("ir_load_valid", {31'd0, ir_valid}, 32'd1);
        check("ir_load_data", {16'd0, ir_out}, {16'd0, want});
        check("req_drop", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            ir_ready = 1'b0;
            jump_req = noise;
            jump_target = 8'($urandom);
            tick();
            check("hold_valid", {31'd0, ir_valid}, 32'd1);
            check("hold_data", {16'd0, ir_out}, {16'd0, want});
            check("hold_quiet", {30'd0, pc_en, mem_req}, 32'd0);
        end
        ir_ready = 1'b1;
        jump_req = jmp;
        jump_target = tgt;
        tick();
        ir_ready = 1'b0;
        jump_req = 1'b0;
        if (halt_adv) halt = 1'b1;
        check("adv_pc_en", {31'd0, pc_en}, 32'd1);
        check("adv_ctrl", {30'd0, pc_ctrl}, jmp ? 32'd3 : 32'd1);
        check("adv_offset", {24'd0, offset_addr}, jmp ? {24'd0, tgt} : 32'd0);
        check("adv_ir_clear", {31'd0, ir_valid}, 32'd0);
        exp_pc = jmp ? {8'h00, tgt} : exp_pc + 16'h0001;
        if (halt_adv) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                check("halt_no_req", {30'd0, mem_req, pc_en}, 32'd0);
            end
            halt = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0; ir_ready = 1'b0;
        jump_req = 1'b0; jump_target = 8'h0; halt = 1'b0;
        exp_pc = 16'h0000;
        tick();
        tick();
        check("rst_outputs", {pc_en, pc_ctrl, offset_addr, mem_req, ir_valid, fetch_err},
              32'd0);
        check("rst_ir", {16'd0, ir_out}, 32'd0);
        rst = 1'b1;

        // directed scenarios: plain fetch, slow ack, decode stall, jump with noise, halt in ADV
        fetch_one(0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        fetch_one(3, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        fetch_one(0, 5, 1'b0, 8'h00, 1'b0, 1'b0);
        fetch_one(1, 2, 1'b1, 8'hA5, 1'b1, 1'b0);
        fetch_one(0, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        fetch_one(0, 1, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            fetch_one(int'($urandom_range(0, 14)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
        end

        // timeout: no ack for 16 request cycles
        do_reset();
        wait_req();
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_req_held", {30'd0, mem_req, fetch_err}, 32'd2);
        end
        tick();
        check("to_err", {30'd0, fetch_err, mem_req}, 32'd2);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_sticky", {29'd0, fetch_err, mem_req, ir_valid}, 32'd4);
        end
        mem_ack = 1'b0;

        // ack in the sixteenth cycle wins over the timeout
        do_reset();
        check("err_cleared", {31'd0, fetch_err}, 32'd0);
        wait_req();
        for (int i = 0; i < 15; i++) tick();
        check("to16_still_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = word_at(mem_addr);
        tick();
        mem_ack = 1'b0;
        check("to16_no_err", {31'd0, fetch_err}, 32'd0);
        check("to16_loaded", {15'd0, ir_valid, ir_out}, {15'd0, 1'b1, word_at(16'h0000)});

        // asynchronous reset in the middle of a request
        do_reset();
        wait_req();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", {pc_en, pc_ctrl, offset_addr, mem_req, ir_valid, fetch_err}, 32'd0);
        check("async_rst_ir", {16'd0, ir_out}, 32'd0);
        mem_ack = 1'b1;
        tick();
        rst = 1'b1;
        exp_pc = 16'h0000;
        tick();
        mem_ack = 1'b0;
        check("no_stale_load", {31'd0, ir_valid}, 32'd0);
        fetch_one(0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        fetch_one(2, 1, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_req();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
